// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// Producer drives operands, the adder answers with a registered result.
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock through one
// narrow carry chain, carry held in a register between chunks.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic clk,
  input  logic rst_n,
  chunked_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic [31:0]      off;
  logic [CHUNK:0]   add;
  logic             last;

  assign off  = 32'(k) * 32'(CHUNK);
  assign add  = {1'b0, a_r[off +: CHUNK]}
              + {1'b0, b_r[off +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
  assign last = (k == KW'(NCHUNK - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Subtract is a + ~b + !cin, so invert b and cin once at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        a_r   <= bus.a;
        b_r   <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.cin ^ bus.sub;
        k     <= '0;
      end else if (state == RUN) begin
        sum_r[off +: CHUNK] <= add[CHUNK-1:0];
        carry <= add[CHUNK];
        k     <= k + 1'b1;
        if (last) begin
          cout_r <= add[CHUNK];
          ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1])
                 && (add[CHUNK-1] != a_r[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: directed plan vectors plus
// random operations checked against an arithmetic reference model.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  chunked_adder_if #(.WIDTH(32)) bus32 ();
  chunked_adder_if #(.WIDTH(8))  bus8 ();

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus32)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input int w, input longint unsigned a, input longint unsigned b,
    input bit cin, input bit sub,
    output longint unsigned s, output bit co, output bit ov);
    longint unsigned m;
    longint sa, sb, ex, hi, lo;
    m  = (64'd1 << w) - 1;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    hi = longint'(64'd1 << (w - 1)) - 1;
    lo = -longint'(64'd1 << (w - 1));
    if (sub) begin
      s  = (a - b - 64'(cin)) & m;
      co = (a >= b + 64'(cin));
      ex = sa - sb - longint'(cin);
    end else begin
      s  = (a + b + 64'(cin)) & m;
      co = ((a + b + 64'(cin)) >> w) != 0;
      ex = sa + sb + longint'(cin);
    end
    ov = (ex > hi) || (ex < lo);
  endfunction

  task automatic wait_done32(output int lat);
    lat = 0;
    while (!bus32.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, output int lat);
    bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = sub;
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.a = $urandom; bus32.b = $urandom;
    bus32.cin = 1'($urandom); bus32.sub = 1'($urandom);
    wait_done32(lat);
  endtask

  task automatic release32();
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
               bus32.in_ready, bus32.out_valid);
    end
    checks++;
    if (bus32.sum !== 32'h0 || bus32.cout !== 1'b0 || bus32.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_res: sum=%h cout=%b ovf=%b want 0/0/0",
               bus32.sum, bus32.cout, bus32.ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va[4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd7};
    logic [31:0] vb[4] = '{32'h0, 32'h1, 32'd7, 32'd5};
    logic        vc[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es[4] = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'd2};
    logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus32.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_ready: in_ready=%b want 1", i, bus32.in_ready);
      end
      run_op(va[i], vb[i], vc[i], vs[i], lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL dir%0d_lat: got %0d want 4", i, lat);
      end
      checks++;
      if (bus32.sum !== es[i] || bus32.cout !== ec[i] || bus32.ovf !== eo[i]) begin
        errors++;
        $display("FAIL dir%0d_res: sum=%h cout=%b ovf=%b want %h/%b/%b",
                 i, bus32.sum, bus32.cout, bus32.ovf, es[i], ec[i], eo[i]);
      end
      release32();
      checks++;
      if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_ret: in_ready=%b out_valid=%b want 1/0",
                 i, bus32.in_ready, bus32.out_valid);
      end
    end
  endtask

  task automatic test_random();
    longint unsigned s;
    bit co, ov;
    logic [31:0] a, b;
    logic cin, sub;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      if (i % 6 == 0) a = 32'h80000000;
      if (i % 6 == 1) b = 32'h0;
      cin = 1'($urandom); sub = 1'($urandom);
      model(32, 64'(a), 64'(b), cin, sub, s, co, ov);
      run_op(a, b, cin, sub, lat);
      checks++;
      if (lat !== 4 || bus32.sum !== s[31:0] || bus32.cout !== co || bus32.ovf !== ov) begin
        errors++;
        $display("FAIL rand%0d: %h %s %h c%b -> sum=%h cout=%b ovf=%b lat=%0d want %h/%b/%b lat=4",
                 i, a, sub ? "-" : "+", b, cin, bus32.sum, bus32.cout,
                 bus32.ovf, lat, s[31:0], co, ov);
      end
      release32();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1;
    logic c1, o1;
    longint unsigned s;
    bit co, ov;
    int lat;
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, lat);
    s1 = bus32.sum; c1 = bus32.cout; o1 = bus32.ovf;
    checks++;
    if (s1 !== 32'h00010000 || lat !== 4) begin
      errors++;
      $display("FAIL bp_first: sum=%h lat=%0d want 00010000 lat=4", s1, lat);
    end
    bus32.a = 32'h40000000; bus32.b = 32'h40000000;
    bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.in_valid = 1'b1;
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus32.sum !== s1 || bus32.cout !== c1 || bus32.ovf !== o1 ||
          bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: sum=%h in_ready=%b out_valid=%b want %h/0/1",
                 i, bus32.sum, bus32.in_ready, bus32.out_valid, s1);
      end
    end
    release32();
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0",
               bus32.in_ready, bus32.out_valid);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%b want 0", bus32.in_ready);
    end
    wait_done32(lat);
    model(32, 64'h40000000, 64'h40000000, 1'b0, 1'b0, s, co, ov);
    checks++;
    if (lat !== 4 || bus32.sum !== s[31:0] || bus32.cout !== co || bus32.ovf !== ov) begin
      errors++;
      $display("FAIL bp_second: sum=%h cout=%b ovf=%b lat=%0d want %h/%b/%b lat=4",
               bus32.sum, bus32.cout, bus32.ovf, lat, s[31:0], co, ov);
    end
    release32();
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    int lat;
    bus32.a = 32'h0F0F0F0F; bus32.b = 32'h01010101;
    bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.sum !== 32'h0 || bus32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b sum=%h in_ready=%b want 0/0/1",
               bus32.out_valid, bus32.sum, bus32.in_ready);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus32.out_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus32.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse: out_valid seen=%b want 0", seen);
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus32.sum !== 32'h23456789 || bus32.cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_fresh: sum=%h cout=%b lat=%0d want 23456789/0 lat=4",
               bus32.sum, bus32.cout, lat);
    end
    release32();
  endtask

  task automatic test_narrow();
    logic [7:0] va[4];
    logic [7:0] vb[4];
    logic vc[4];
    logic vs[4];
    longint unsigned s;
    bit co, ov;
    int lat;
    va[0] = 8'h80; vb[0] = 8'h80; vc[0] = 1'b0; vs[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom);
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      model(8, 64'(va[i]), 64'(vb[i]), vc[i], vs[i], s, co, ov);
      bus8.a = va[i]; bus8.b = vb[i]; bus8.cin = vc[i]; bus8.sub = vs[i];
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      while (!bus8.out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 1 || bus8.sum !== s[7:0] || bus8.cout !== co || bus8.ovf !== ov) begin
        errors++;
        $display("FAIL narrow%0d: sum=%h cout=%b ovf=%b lat=%0d want %h/%b/%b lat=1",
                 i, bus8.sum, bus8.cout, bus8.ovf, lat, s[7:0], co, ov);
      end
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
